tensor_mem_slave: RTL and testbench

- On-chip word-addressed tensor memory that serves the read (ar/r) and write (aw/w/b) channels of tensor_interface.
- Connects directly to tensor_interface's ar_*, r_*, aw_*, w_*, b_* ports. It replaces the bench-driven memory model in system builds.
- Single-beat reads (one AR gives one R beat) and burst writes (one AW, then W beats up to w_last, then one B).
- Read and write paths are independent and run concurrently.

---
 rtl/tensor_if_pkg.sv | 23 ++
 rtl/tensor_rd_fifo.sv | 55 +++++
 rtl/tensor_mem_slave.sv | 151 +++++++++++++++
 tb/tb_tensor_mem_slave.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tensor_if_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tensor_if_pkg
// Brief    : Shared widths, response codes and write-state encoding for the
//            tensor_interface memory channels.
// Revision : 1.0
// ============================================================================
package tensor_if_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    localparam logic RESP_OKAY = 1'b0;
    localparam logic RESP_ERR  = 1'b1;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wstate_e;

endpackage
`default_nettype wire

// File: rtl/tensor_rd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tensor_rd_fifo
// Brief    : Two-entry show-ahead FIFO buffering read responses.
// Revision : 1.0
// ============================================================================
module tensor_rd_fifo #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] r_slot [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_pop;

    assign w_pop      = pop && (r_count != 2'd0);
    assign head_data  = r_slot[r_rd_ptr];
    assign head_valid = (r_count != 2'd0);
    assign count      = r_count;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_slot[0] <= '0;
            r_slot[1] <= '0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= 2'd0;
        end else begin
            if (push) begin
                r_slot[r_wr_ptr] <= push_data;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/tensor_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : tensor_mem_slave
// Brief    : Word-addressed on-chip memory serving single-beat reads and
//            burst writes on independent channels.
// Revision : 1.0
// ============================================================================
module tensor_mem_slave
    import tensor_if_pkg::*;
#(
    parameter int                DEPTH     = 2048,
    parameter int                ADDR_W    = tensor_if_pkg::ADDR_W,
    parameter int                DATA_W    = tensor_if_pkg::DATA_W,
    parameter string             INIT_FILE = "",
    parameter logic [DATA_W-1:0] OOR_DATA  = 32'hDEAD_BEEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] ar_addr,
    input  logic              ar_valid,
    output logic              ar_ready,
    output logic [DATA_W-1:0] r_data,
    output logic              r_last,
    output logic              r_valid,
    input  logic              r_ready,
    input  logic [ADDR_W-1:0] aw_addr,
    input  logic              aw_valid,
    output logic              aw_ready,
    input  logic [DATA_W-1:0] w_data,
    input  logic              w_last,
    input  logic              w_valid,
    output logic              w_ready,
    output logic              b_resp,
    output logic              b_valid,
    input  logic              b_ready
);

    localparam int              c_IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] c_DEPTH = DEPTH[ADDR_W:0];

    logic [DATA_W-1:0] mem [DEPTH];

    // Handshake readies stay low for the cycle reset is held.
    logic r_out_en;
    always_ff @(posedge clock) begin
        r_out_en <= reset_n;
    end

    // ---------------------------------------------------------------- read
    logic              r_inflight;
    logic [DATA_W-1:0] r_rd_word;
    logic              w_ar_fire;
    logic              w_r_pop;
    logic              w_rd_in_range;
    logic [1:0]        w_fifo_cnt;
    logic              w_fifo_valid;
    logic [DATA_W-1:0] w_fifo_data;
    logic [2:0]        w_rd_occupancy;

    assign w_rd_in_range  = ({1'b0, ar_addr} < c_DEPTH);
    assign w_rd_occupancy = {1'b0, w_fifo_cnt} + {2'b00, r_inflight};
    assign w_r_pop        = w_fifo_valid && r_ready;
    assign ar_ready       = r_out_en && ((w_rd_occupancy < 3'd2) || w_r_pop);
    assign w_ar_fire      = ar_valid && ar_ready;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_ar_fire;
        end
    end

    tensor_rd_fifo #(
        .WIDTH (DATA_W)
    ) u_rd_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (r_inflight),
        .push_data  (r_rd_word),
        .pop        (w_r_pop),
        .head_data  (w_fifo_data),
        .head_valid (w_fifo_valid),
        .count      (w_fifo_cnt)
    );

    assign r_data  = w_fifo_data;
    assign r_valid = w_fifo_valid;
    assign r_last  = w_fifo_valid;

    // --------------------------------------------------------------- write
    wstate_e           r_wstate;
    logic [ADDR_W-1:0] r_wptr;
    logic              r_err;
    logic              w_aw_fire;
    logic              w_w_fire;
    logic              w_wr_in_range;

    assign aw_ready      = r_out_en && (r_wstate == W_IDLE);
    assign w_ready       = (r_wstate == W_DATA);
    assign b_valid       = (r_wstate == W_RESP);
    assign b_resp        = (b_valid && r_err) ? RESP_ERR : RESP_OKAY;
    assign w_aw_fire     = aw_valid && aw_ready;
    assign w_w_fire      = w_valid && w_ready;
    assign w_wr_in_range = ({1'b0, r_wptr} < c_DEPTH);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_wstate <= W_IDLE;
            r_wptr   <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_fire) begin
                        r_wptr   <= aw_addr;
                        r_err    <= 1'b0;
                        r_wstate <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_w_fire) begin
                        if (!w_wr_in_range) begin
                            r_err <= 1'b1;
                        end
                        r_wptr <= r_wptr + 1'b1;
                        if (w_last) begin
                            r_wstate <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (b_ready) begin
                        r_wstate <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Read and write share one edge so a same-address pair reads old data.
    always_ff @(posedge clock) begin
        if (reset_n && w_w_fire && w_wr_in_range) begin
            mem[r_wptr[c_IDX_W-1:0]] <= w_data;
        end
        r_rd_word <= w_rd_in_range ? mem[ar_addr[c_IDX_W-1:0]] : OOR_DATA;
    end

endmodule
`default_nettype wire

// File: tb/tb_tensor_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_tensor_mem_slave
// Brief    : Directed and randomized self-checking bench for tensor_mem_slave.
// Revision : 1.0
// ============================================================================
module tb_tensor_mem_slave;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] ar_addr = '0;
    logic        ar_valid = 1'b0;
    logic        ar_ready;
    logic [31:0] r_data;
    logic        r_last;
    logic        r_valid;
    logic        r_ready = 1'b0;
    logic [15:0] aw_addr = '0;
    logic        aw_valid = 1'b0;
    logic        aw_ready;
    logic [31:0] w_data = '0;
    logic        w_last = 1'b0;
    logic        w_valid = 1'b0;
    logic        w_ready;
    logic        b_resp;
    logic        b_valid;
    logic        b_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [0:2047];
    logic [31:0] wbuf    [0:2047];

    tensor_mem_slave dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .ar_addr  (ar_addr),
        .ar_valid (ar_valid),
        .ar_ready (ar_ready),
        .r_data   (r_data),
        .r_last   (r_last),
        .r_valid  (r_valid),
        .r_ready  (r_ready),
        .aw_addr  (aw_addr),
        .aw_valid (aw_valid),
        .aw_ready (aw_ready),
        .w_data   (w_data),
        .w_last   (w_last),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .b_resp   (b_resp),
        .b_valid  (b_valid),
        .b_ready  (b_ready)
    );

    always #5 clock = ~clock;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic sel_ready(input int sel);
        case (sel)
            0:       return ar_ready;
            1:       return aw_ready;
            2:       return w_ready;
            3:       return b_valid;
            default: return r_valid;
        endcase
    endfunction

    // Returns mid-cycle with the selected ready/valid high; caller then ticks.
    task automatic hs_wait(input int sel, input string tag);
        int n;
        n = 0;
        #1;
        while (sel_ready(sel) !== 1'b1 && n < 50) begin
            tick;
            #1;
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $error("FAIL %s_timeout: observed no handshake expected handshake within 50 cycles", tag);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [15:0] a);
        if (int'(a) < 2048) return ref_mem[a[10:0]];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic write_burst(input logic [15:0] addr, input int n, input string tag);
        logic        exp_err;
        logic [15:0] a;
        exp_err  = 1'b0;
        aw_addr  = addr;
        aw_valid = 1'b1;
        hs_wait(1, tag);
        tick;
        aw_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            a       = addr + 16'(k);
            w_data  = wbuf[k];
            w_last  = (k == n - 1);
            w_valid = 1'b1;
            hs_wait(2, tag);
            tick;
            if (int'(a) < 2048) ref_mem[a[10:0]] = wbuf[k];
            else                exp_err = 1'b1;
        end
        w_valid = 1'b0;
        w_last  = 1'b0;
        b_ready = 1'b1;
        hs_wait(3, tag);
        chk({tag, "_bresp"}, 32'(b_resp), 32'(exp_err));
        tick;
        b_ready = 1'b0;
    endtask

    task automatic read_one(input logic [15:0] addr, input int stall, input string tag);
        ar_addr  = addr;
        ar_valid = 1'b1;
        r_ready  = 1'b0;
        hs_wait(0, tag);
        tick;
        ar_valid = 1'b0;
        repeat (stall) tick;
        r_ready = 1'b1;
        hs_wait(4, tag);
        chk({tag, "_data"}, r_data, ref_read(addr));
        chk({tag, "_last"}, 32'(r_last), 32'd1);
        tick;
        r_ready = 1'b0;
    endtask

    initial begin
        int          acc;
        logic [15:0] a;
        int          len;

        // Reset state
        repeat (2) tick;
        chk("rst_ar_ready", 32'(ar_ready), 0);
        chk("rst_r_valid",  32'(r_valid),  0);
        chk("rst_r_last",   32'(r_last),   0);
        chk("rst_r_data",   r_data,        0);
        chk("rst_aw_ready", 32'(aw_ready), 0);
        chk("rst_w_ready",  32'(w_ready),  0);
        chk("rst_b_valid",  32'(b_valid),  0);
        chk("rst_b_resp",   32'(b_resp),   0);
        reset_n = 1'b1;
        tick;
        chk("post_rst_aw_ready", 32'(aw_ready), 1);

        // Preload whole memory with i + 0x100
        for (int i = 0; i < 2048; i++) wbuf[i] = 32'h100 + 32'(i);
        write_burst(16'd0, 2048, "preload");

        // Single read latency
        ar_addr  = 16'd5;
        ar_valid = 1'b1;
        r_ready  = 1'b1;
        #1;
        chk("lat_ar_ready", 32'(ar_ready), 1);
        tick;
        ar_valid = 1'b0;
        chk("lat_r_valid_n", 32'(r_valid), 0);
        tick;
        chk("lat_r_valid_n1", 32'(r_valid), 1);
        chk("lat_r_data", r_data, 32'h105);
        chk("lat_r_last", 32'(r_last), 1);
        tick;

        // Back-to-back reads 0..7
        for (int i = 0; i < 8; i++) begin
            ar_addr  = 16'(i);
            ar_valid = 1'b1;
            #1;
            chk("b2b_ar_ready", 32'(ar_ready), 1);
            tick;
            if (i > 0) begin
                chk("b2b_r_valid", 32'(r_valid), 1);
                chk("b2b_r_data", r_data, 32'h100 + 32'(i - 1));
            end
        end
        ar_valid = 1'b0;
        tick;
        chk("b2b_last_valid", 32'(r_valid), 1);
        chk("b2b_last_data", r_data, 32'h107);
        tick;
        r_ready = 1'b0;

        // Backpressure: only two reads accepted
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (ar_ready) begin
                ar_addr  = 16'(20 + acc);
                ar_valid = 1'b1;
                acc++;
            end
            tick;
            ar_valid = 1'b0;
        end
        chk("bp_accepted", 32'(acc), 2);
        chk("bp_ar_ready_low", 32'(ar_ready), 0);
        r_ready = 1'b1;
        #1;
        chk("bp_data0", r_data, 32'h114);
        tick;
        chk("bp_valid1", 32'(r_valid), 1);
        chk("bp_data1", r_data, 32'h115);
        tick;
        chk("bp_drained", 32'(r_valid), 0);
        chk("bp_ar_ready_back", 32'(ar_ready), 1);
        r_ready = 1'b0;

        // Burst write at 10 and readback
        wbuf[0] = 32'hAAAA0001;
        wbuf[1] = 32'hAAAA0002;
        wbuf[2] = 32'hAAAA0003;
        write_burst(16'd10, 3, "wr10");
        for (int i = 10; i < 13; i++) read_one(16'(i), 0, "rd10");

        // Burst crossing the end of memory
        wbuf[0] = 32'hBBBB0001;
        wbuf[1] = 32'hBBBB0002;
        write_burst(16'd2047, 2, "wr_edge");
        read_one(16'd2047, 1, "rd_2047");
        read_one(16'd2048, 0, "rd_oor");

        // Same-address read and write on one edge: read-first
        aw_addr  = 16'd50;
        aw_valid = 1'b1;
        hs_wait(1, "rf_aw");
        tick;
        aw_valid = 1'b0;
        w_data   = 32'h7777_0050;
        w_last   = 1'b1;
        w_valid  = 1'b1;
        ar_addr  = 16'd50;
        ar_valid = 1'b1;
        r_ready  = 1'b1;
        #1;
        chk("rf_w_ready", 32'(w_ready), 1);
        chk("rf_ar_ready", 32'(ar_ready), 1);
        tick;
        w_valid  = 1'b0;
        w_last   = 1'b0;
        ar_valid = 1'b0;
        b_ready  = 1'b1;
        chk("rf_b_valid", 32'(b_valid), 1);
        chk("rf_b_resp", 32'(b_resp), 0);
        tick;
        chk("rf_old_data", r_data, ref_read(16'd50));
        ref_mem[50] = 32'h7777_0050;
        tick;
        b_ready = 1'b0;
        r_ready = 1'b0;
        read_one(16'd50, 0, "rf_new");

        // Reset during a burst
        aw_addr  = 16'd100;
        aw_valid = 1'b1;
        hs_wait(1, "mr_aw");
        tick;
        aw_valid = 1'b0;
        w_data   = 32'h5555_0001;
        w_valid  = 1'b1;
        hs_wait(2, "mr_w1");
        tick;
        ref_mem[100] = 32'h5555_0001;
        w_data  = 32'h5555_0002;
        reset_n = 1'b0;
        tick;
        chk("mr_ar_ready", 32'(ar_ready), 0);
        chk("mr_r_valid",  32'(r_valid),  0);
        chk("mr_r_last",   32'(r_last),   0);
        chk("mr_r_data",   r_data,        0);
        chk("mr_aw_ready", 32'(aw_ready), 0);
        chk("mr_w_ready",  32'(w_ready),  0);
        chk("mr_b_valid",  32'(b_valid),  0);
        chk("mr_b_resp",   32'(b_resp),   0);
        w_valid = 1'b0;
        reset_n = 1'b1;
        tick;
        chk("mr_aw_back", 32'(aw_ready), 1);
        chk("mr_no_b", 32'(b_valid), 0);
        read_one(16'd100, 0, "mr_kept");
        read_one(16'd101, 0, "mr_unwritten");
        wbuf[0] = 32'h6666_0200;
        write_burst(16'd200, 1, "mr_new_aw");
        read_one(16'd200, 0, "mr_new_rd");

        // Randomized mix against the reference model
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                len = int'($urandom_range(1, 4));
                case ($urandom_range(0, 3))
                    0:       a = 16'(2045 + $urandom_range(0, 2));
                    1:       a = 16'hFFFE;
                    default: a = 16'($urandom_range(0, 2047));
                endcase
                for (int k = 0; k < len; k++) wbuf[k] = $urandom;
                write_burst(a, len, "rnd_wr");
            end else begin
                if ($urandom_range(0, 7) == 0) a = 16'(2048 + $urandom_range(0, 60000));
                else                           a = 16'($urandom_range(0, 2047));
                read_one(a, int'($urandom_range(0, 3)), "rnd_rd");
            end
        end
        read_one(16'd0, 0, "rnd_wrap0");
        read_one(16'd1, 0, "rnd_wrap1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
